// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the frame-buffer writer.
package frame_writer_pkg;

    // Writer control states.
    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        WAIT_SOF = 2'd1,
        WRITE    = 2'd2
    } fw_state_e;

    // Default raster geometry (VGA 640x480).
    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;
    localparam int unsigned FRAME_PIXELS     = H_ACTIVE_DEFAULT * V_ACTIVE_DEFAULT;

    // Frame-buffer address and pixel code widths.
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 3;

    // Address of the last pixel of an h x v frame.
    function automatic logic [ADDR_W-1:0] last_addr(input int unsigned h, input int unsigned v);
        return ADDR_W'(h * v - 1);
    endfunction

endpackage

// File: rtl/frame_writer_addr_counter.sv
// Raster address counter: load-0, load-1, increment with wrap at LAST,
// and a terminal-count flag that is high while the count equals LAST.
module addr_counter
    import frame_writer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LAST = last_addr(H_ACTIVE_DEFAULT, V_ACTIVE_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load0_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    // Next count: load-0 beats load-1 beats increment; increment wraps at LAST
    // so the count never leaves 0..LAST.
    always_comb begin
        count_d = count_q;
        if (load0_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = (LAST == '0) ? '0 : ADDR_W'(1);
        end else if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register, synchronous reset to 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/frame_writer.sv
// Frame-buffer writer: clears the BRAM to code 0, then writes incoming
// pixel beats in raster order, resynchronising on start-of-frame.
//
// Handshake: a beat is transferred in a cycle where pix_valid and pix_ready
// are both 1; the upstream may present or withdraw a beat freely while
// pix_ready is 0. pix_ready is low in CLEAR, during reset, and in any cycle
// where clear_req is high, so a clear request never swallows a beat.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              ready,
    output logic              sof_error
);

    localparam logic [ADDR_W-1:0] LAST = last_addr(H_ACTIVE, V_ACTIVE);

    fw_state_e         state_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic              ready_q;
    logic              sof_error_q;

    logic [ADDR_W-1:0] cnt;
    logic              cnt_tc;
    logic              cnt_load0;
    logic              cnt_load1;
    logic              cnt_inc;
    logic              accept;

    assign pix_ready = !reset && !clear_req && (state_q != CLEAR);
    assign accept    = pix_valid && pix_ready;

    // Counter control: clear restarts at 0, any sof beat resyncs to 1,
    // clear sweeps and ordinary frame beats advance by one.
    always_comb begin
        cnt_load0 = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (clear_req) begin
            cnt_load0 = 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_inc = 1'b1;
                end
                WAIT_SOF: begin
                    if (accept && pix_sof) begin
                        cnt_load1 = 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (pix_sof) begin
                            cnt_load1 = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_load0 = 1'b1;
                end
            endcase
        end
    end

    addr_counter #(
        .LAST (LAST)
    ) u_addr_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .load0_i (cnt_load0),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    // Control FSM with registered write port, ready level and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ready_q     <= 1'b0;
            sof_error_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (clear_req) begin
                // Entering or restarting the clear; no write this cycle.
                state_q <= CLEAR;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    CLEAR: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt;
                        wr_data_q <= '0;
                        if (cnt_tc) begin
                            state_q <= WAIT_SOF;
                        end
                    end
                    WAIT_SOF: begin
                        // Non-sof beats are consumed and dropped here.
                        if (accept && pix_sof) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= '0;
                            wr_data_q <= pix_data;
                            state_q   <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (accept) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= pix_data;
                            if (pix_sof) begin
                                // Early sof: restart the frame, flag it, keep ready.
                                wr_addr_q   <= '0;
                                sof_error_q <= 1'b1;
                            end else begin
                                wr_addr_q <= cnt;
                                if (cnt_tc) begin
                                    ready_q <= 1'b1;
                                    state_q <= WAIT_SOF;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= CLEAR;
                    end
                endcase
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign ready     = ready_q;
    assign sof_error = sof_error_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer on a reduced 124x100 raster.
module tb_frame_writer;

  localparam int H = 124;
  localparam int V = 100;
  localparam int FRAME = H * V;
  localparam int LAST = FRAME - 1;

  logic        clock;
  logic        reset;
  logic        clear_req;
  logic        pix_valid;
  logic        pix_sof;
  logic [2:0]  pix_data;
  logic        pix_ready;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic        ready;
  logic        sof_error;

  // expected write: {ready, addr[18:0], data[2:0]}
  logic [22:0] exp_q[$];
  int total;
  int bad;

  frame_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear_req (clear_req),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ready     (ready),
    .sof_error (sof_error)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic rdy, input int addr, input logic [2:0] data);
    logic [18:0] a;
    a = 19'(addr);
    exp_q.push_back({rdy, a, data});
  endtask

  task automatic push_clear();
    for (int i = 0; i < FRAME; i++) push_exp(1'b0, i, 3'd0);
  endtask

  // scoreboard: every presented write must match the oldest expectation
  task automatic monitor();
    logic [22:0] e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'd0, wr_addr}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {13'd0, wr_addr}, {13'd0, e[21:3]});
        check("wr_data", {29'd0, wr_data}, {29'd0, e[2:0]});
        check("ready_with_wr", {31'd0, ready}, {31'd0, e[22]});
      end
    end
  endtask

  // inputs set at negedge are sampled at the next posedge; outputs of
  // that posedge are checked at the following negedge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    monitor();
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 3'd0;
  endtask

  // driver: offer one beat that the writer must accept
  task automatic beat(input logic sof, input logic [2:0] data, input logic exp_wr,
                      input logic exp_rdy, input int addr);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = data;
    if (!pix_ready) check("pix_ready_at_beat", {31'd0, pix_ready}, 32'd1);
    if (exp_wr) push_exp(exp_rdy, addr, data);
    tick();
    idle();
  endtask

  // run a full clear sweep (the first write appears on the first tick)
  task automatic run_clear(input string tag, input int pre_low);
    int low;
    low = pre_low;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (i < LAST && pix_ready === 1'b0) low++;
      if (i == LAST) check({tag, "_prdy_after_last"}, {31'd0, pix_ready}, 32'd1);
    end
    check({tag, "_prdy_low_cycles"}, low, FRAME - 1 + pre_low);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [2:0] d;
    total = 0;
    bad = 0;
    reset = 1'b1;
    clear_req = 1'b0;
    idle();
    @(negedge clock);
    repeat (3) tick();

    // reset state
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {13'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {29'd0, wr_data}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_sof_error", {31'd0, sof_error}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);

    // reset, then idle: full clear sweep
    reset = 1'b0;
    push_clear();
    run_clear("clr0", 0);
    check("clr0_ready", {31'd0, ready}, 32'd0);
    repeat (5) tick();
    check("idle_ready", {31'd0, ready}, 32'd0);

    // full frame with random gaps
    for (int k = 0; k < FRAME; k++) begin
      if ($urandom_range(0, 7) == 0) tick();
      d = 3'($urandom_range(0, 7));
      beat(k == 0, d, 1'b1, k == LAST, k);
      if (k == LAST - 1) check("frame1_ready_before_last", {31'd0, ready}, 32'd0);
    end
    check("frame1_queue_drained", exp_q.size(), 0);
    check("frame1_ready", {31'd0, ready}, 32'd1);
    check("frame1_sof_error", {31'd0, sof_error}, 32'd0);

    // non-sof beats in WAIT_SOF are dropped, then sof starts at address 0
    for (int k = 0; k < 3; k++) beat(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b1, 0);
    check("drop_queue_empty", exp_q.size(), 0);
    beat(1'b1, 3'd5, 1'b1, 1'b1, 0);
    for (int k = 1; k < 1000; k++) beat(1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b1, k);
    check("pre_midsof_error", {31'd0, sof_error}, 32'd0);

    // mid-frame sof at beat 1000 restarts the frame at address 0
    beat(1'b1, 3'd6, 1'b1, 1'b1, 0);
    check("midsof_error", {31'd0, sof_error}, 32'd1);
    check("midsof_ready", {31'd0, ready}, 32'd1);
    for (int k = 1; k < 5000; k++) beat(1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b1, k);
    check("frame2_queue_drained", exp_q.size(), 0);

    // clear_req with a beat offered: beat refused, ready drops, full clear
    clear_req = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 3'd7;
    #1;
    check("clrreq_pix_ready", {31'd0, pix_ready}, 32'd0);
    tick();
    clear_req = 1'b0;
    idle();
    check("clrreq_ready_drop", {31'd0, ready}, 32'd0);
    check("clrreq_no_write", {31'd0, wr_en}, 32'd0);
    push_clear();
    run_clear("clr1", pix_ready === 1'b0 ? 1 : 0);
    check("clr1_ready", {31'd0, ready}, 32'd0);
    check("clr1_sof_error_sticky", {31'd0, sof_error}, 32'd1);

    // reset during a clear at address 12345
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_clear();
    repeat (12345) tick();
    check("pre_rst_queue", exp_q.size(), FRAME - 12345);
    reset = 1'b1;
    tick();
    check("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_mid_sof_error", {31'd0, sof_error}, 32'd0);
    exp_q.delete();
    reset = 1'b0;
    push_clear();
    run_clear("clr2", 0);
    check("clr2_ready", {31'd0, ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
